mux_rr_arbiter: RTL
===================

# mux_rr_arbiter

Round-robin arbiter and sequencer for the shared 4:1 multiplexer datapath. Four requesters compete for one output channel; the block picks a winner, drives the 2-bit mux select and a one-hot grant, and presents the selected word on a valid/ready output handshake. It sits directly in front of the 4:1 mux and owns its select lines, so no requester drives `sel` directly.

## Interface
Parameters:
- `WIDTH`, 8: data width per requester.
- `MAX_BURST`, 4: maximum consecutive beats per grant when burst is compiled in. Legal range is 1..15.

Ports:
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req`, in, 4: per-requester request. Bit k belongs to requester k.
- `din`, in, 4*WIDTH: flattened requester data. Requester k uses `din[k*WIDTH +: WIDTH]`.
- `gnt`, out, 4: one-hot grant, registered.
- `sel`, out, 2: mux select, registered. Equals the index of the `gnt` bit while granted.
- `out_valid`, out, 1: output word valid.
- `out_data`, out, WIDTH: selected word.
- `out_ready`, in, 1: downstream accept.
- `busy`, out, 1: high whenever the FSM is in XFER.

## Operation
- States:
  - IDLE: `gnt`=0, `out_valid`=0.
  - XFER: a grant is held.
- Arbitration uses a rotating priority pointer `ptr` (2 bits). The winner is the first set `req` bit found at or after `ptr`, searching upward with wrap (3 → 0).
- IDLE → XFER when any `req` is set. `gnt`, `sel` and `busy` load on that edge.
- In XFER:
  - `out_valid` = `req[sel]`.
  - `out_data` = `din[sel]` when `out_valid` is high, otherwise 0.
- Accept is `out_valid & out_ready`. On accept:
  - `ptr` ← `sel`+1 (mod 4).
  - If any `req` bit other than the just-served one is set, re-arbitrate on the same edge with the new pointer and stay in XFER. There is no idle bubble.
  - If only the just-served requester's bit is set, it is granted again on the same edge and the FSM stays in XFER.
  - If no `req` bit is set, go to IDLE.
- Withdraw: if `req[sel]` drops in XFER without an accept, go to IDLE on the next edge. `ptr` is unchanged.
- Requesters must hold `din` stable while granted and until accepted.
- Reset (asynchronous, at any time, including mid-transfer) clears all of the following:
  - FSM state → IDLE.
  - `gnt`, `sel`, `ptr`, `busy`, `out_valid`, `out_data`, and the beat counter → 0.
  - An in-flight beat is dropped.

## Timing
- Request to grant: 1 cycle. `req` is sampled in IDLE, and `gnt`/`out_valid` are high on the following cycle.
- Output path: `out_valid` and `out_data` are combinational from registered `sel`/`gnt` plus the current `req`/`din`. There is no extra register stage.
- Sustained throughput: 1 beat per cycle while requests and `out_ready` are continuous.
- Stall: `out_ready`=0 holds `gnt`, `sel` and `out_data` unchanged indefinitely.
- Simultaneous requests: resolved purely by `ptr`. Under continuous contention every active requester is served within 4 beats (within 4×`MAX_BURST` beats with burst enabled).

## Configuration
- Macro: `MUX_ARB_BURST_EN`.
- Defined:
  - A 4-bit beat counter is compiled in. It counts accepts under the current grant.
  - On accept, if `req[sel]` is still high and the count is less than `MAX_BURST`−1, the grant is kept and `ptr` is not advanced.
  - Otherwise the normal rotation applies and the counter clears.
  - The counter also clears on every new grant and on reset.
- Undefined: no counter. Every accept triggers rotation as described in Operation, giving one beat per grant.

## Structure
- Shared package `mux_arb_pkg` holds:
  - `N_REQ`=4 and `SEL_W`=2.
  - The state encoding (IDLE=0, XFER=1).
- One sub-module: `rr_pick4`.
  - Combinational.
  - Inputs: `req`[3:0] and `ptr`[1:0].
  - Outputs: `any`, `idx`[1:0] and one-hot `oh`[3:0].
- The top level holds:
  - The FSM.
  - The `ptr`, `sel`, `gnt` and counter registers.
  - The output mux.

## Test plan
- Reset then idle: `req`=0000 for 5 cycles → `gnt`=0000, `sel`=0, `out_valid`=0, `out_data`=0, `busy`=0.
- Single requester: `req`=0100, `din[2]`=8'hA5, `out_ready`=1 → one cycle later `gnt`=0100, `sel`=2, `out_data`=A5, `out_valid`=1; after accept `ptr`=3.
- Full contention (burst disabled): `req`=1111 held, `out_ready`=1, `ptr`=0 → grant order 0,1,2,3,0, one beat per cycle with no gaps.
- Backpressure: `req`=0010 with `out_ready`=0 for 3 cycles, then 1 → `gnt`=0010 and `out_data` stable for all 4 cycles; exactly one accept.
- Withdraw and reset: `req[1]` drops while granted and not accepted → IDLE next edge with `ptr` unchanged. A separate case pulses `rst_n` low mid-XFER → all outputs read 0 immediately, without waiting for a clock edge.
- Burst (`MUX_ARB_BURST_EN`, `MAX_BURST`=3): `req`=0011 held, `out_ready`=1 → grant order 0,0,0,1,1,1,0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared constants for the 4-requester round-robin mux arbiter.
// Holds requester count, select width and the legacy-compatible FSM encoding.
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first set req bit at or after ptr,
// searching upward with wrap.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx,
    output logic [N_REQ-1:0] oh
);

    logic [SEL_W-1:0] cand;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves a value held and no latch is inferred.
    always_comb begin
        any  = |req;
        idx  = '0;
        cand = '0;
        // Walk from the farthest offset down so the nearest hit wins last.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                idx = cand;
            end
        end
        oh = any ? (N_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter/sequencer owning the select lines of a shared 4:1 mux.
// Optional burst grants are compiled in with `define MUX_ARB_BURST_EN.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] din,
    output logic [N_REQ-1:0]       gnt,
    output logic [SEL_W-1:0]       sel,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   out_ready,
    output logic                   busy
);

    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
        $error("mux_rr_arbiter: MAX_BURST must be within 1..15");
    end

    logic [0:0]       state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;

    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_oh;
    logic [SEL_W-1:0] pick_ptr;
    logic             accept;
    logic             hold_grant;

    assign busy      = (state_q == ST_XFER);
    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign out_valid = busy & req[sel_q];
    assign out_data  = out_valid ? din[sel_q*WIDTH +: WIDTH] : '0;
    assign accept    = out_valid & out_ready;

    // While granted the picker only matters on accept, when ptr becomes sel+1.
    assign pick_ptr = busy ? sel_q + SEL_W'(1) : ptr_q;

    rr_pick4 u_pick (
        .req (req),
        .ptr (pick_ptr),
        .any (pick_any),
        .idx (pick_idx),
        .oh  (pick_oh)
    );

`ifdef MUX_ARB_BURST_EN
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    logic [3:0] cnt_q, cnt_d;

    assign hold_grant = accept && (cnt_q < BURST_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (hold_grant) begin
            cnt_d = cnt_q + 4'd1;
        end else if (accept || (!busy && pick_any)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign hold_grant = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_XFER;
                    sel_d   = pick_idx;
                    gnt_d   = pick_oh;
                end
            end
            default: begin
                if (accept && !hold_grant) begin
                    ptr_d = sel_q + SEL_W'(1);
                    if (pick_any) begin
                        sel_d = pick_idx;
                        gnt_d = pick_oh;
                    end else begin
                        state_d = ST_IDLE;
                        sel_d   = '0;
                        gnt_d   = '0;
                    end
                end else if (!req[sel_q]) begin
                    // Withdrawn before accept: drop the grant, keep the pointer.
                    state_d = ST_IDLE;
                    sel_d   = '0;
                    gnt_d   = '0;
                end
            end
        endcase
    end

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
        end
    end

endmodule
